j1_uart_io: RTL and testbench

J1_UART_IO -- requirements
Module: j1_uart_io

---
 rtl/j1_io_pkg.sv | 21 ++
 rtl/j1_io_fifo.sv | 62 ++++++
 rtl/j1_uart_io.sv | 188 ++++++++++++++++++
 tb/tb_j1_uart_io.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_io_pkg.sv
// Shared constants and types for the J1 UART I/O block.
package j1_io_pkg;

  // I/O register addresses.
  localparam logic [15:0] AddrData = 16'h1000;
  localparam logic [15:0] AddrStat = 16'h2000;

  // STAT register bit positions.
  localparam int unsigned StatTxBusy    = 0;
  localparam int unsigned StatRxValid   = 1;
  localparam int unsigned StatRxOverrun = 2;

  // Receive framing states.
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/j1_io_fifo.sv
// Small circular FIFO for received bytes. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped.
module j1_io_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pop is resolved first so a full FIFO can take a push.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only visible after it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/j1_uart_io.sv
// Memory-mapped UART for the J1 CPU: DATA and STAT registers, 8N1 transmit,
// oversampled receive into a 4-entry FIFO with a sticky overrun flag.
module j1_uart_io
  import j1_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned WIDTH        = 16
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] io_din,
  input  logic             uart_rx,
  output logic             uart_tx
);

  localparam int unsigned      BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] BaudHalf = BaudW'(CLKS_PER_BIT / 2);

  // Transmit state.
  logic             tx_busy_q, tx_busy_d;
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [BaudW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic             tx_start;

  // Receive state.
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [BaudW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_push;
  logic             rx_overrun_q, rx_overrun_d;

  logic             data_rd, stat_rd;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic             unused_dout;

  assign unused_dout = ^dout;
  assign data_rd     = io_rd && (mem_addr == AddrData);
  assign stat_rd     = io_rd && (mem_addr == AddrStat);
  assign uart_tx     = tx_busy_q ? tx_shift_q[0] : 1'b1;

  j1_io_fifo #(
    .DEPTH(4),
    .WIDTH(8)
  ) u_rx_fifo (
    .clk   (clk),
    .resetq(resetq),
    .push  (rx_push),
    .pop   (data_rd),
    .din   (rx_shift_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Transmitter: shift out {stop, data, start}, one bit per baud period.
  always_comb begin
    tx_start   = io_wr && (mem_addr == AddrData) && !tx_busy_q;
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    if (tx_start) begin
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, dout[7:0], 1'b0};
      tx_baud_d  = '0;
      tx_bit_d   = '0;
    end else if (tx_busy_q) begin
      if (tx_baud_q == BaudLast) begin
        tx_baud_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_baud_d = tx_baud_q + BaudW'(1);
      end
    end
  end

  // Receiver: the detection cycle counts as the first of the half-bit wait,
  // so every later sample lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_baud_d  = BaudW'(1);
        end
      end
      RxStart: begin
        if (rx_baud_q == BaudHalf) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_baud_d = rx_baud_q + BaudW'(1);
        end
      end
      RxData: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_baud_d = rx_baud_q + BaudW'(1);
        end
      end
      RxStop: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_push    = rx_sync_q;
          rx_state_d = RxIdle;
        end else begin
          rx_baud_d = rx_baud_q + BaudW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Overrun: a STAT read clears it, a dropped byte in the same cycle sets it again.
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (stat_rd) rx_overrun_d = 1'b0;
    if (rx_push && fifo_full && !data_rd) rx_overrun_d = 1'b1;
  end

  // Read mux, purely combinational so the CPU can latch it in the strobe cycle.
  always_comb begin
    io_din = '0;
    if (mem_addr == AddrData) begin
      if (!fifo_empty) io_din[7:0] = fifo_head;
    end else if (mem_addr == AddrStat) begin
      io_din[StatTxBusy]    = tx_busy_q;
      io_din[StatRxValid]   = !fifo_empty;
      io_din[StatRxOverrun] = rx_overrun_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      tx_busy_q    <= 1'b0;
      tx_shift_q   <= '1;
      tx_baud_q    <= '0;
      tx_bit_q     <= '0;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_baud_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_busy_q    <= tx_busy_d;
      tx_shift_q   <= tx_shift_d;
      tx_baud_q    <= tx_baud_d;
      tx_bit_q     <= tx_bit_d;
      rx_meta_q    <= uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      rx_baud_q    <= rx_baud_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

endmodule

// File: tb/tb_j1_uart_io.sv
// Self-checking bench for j1_uart_io with CLKS_PER_BIT=4.
module tb_j1_uart_io;

  localparam int unsigned Cpb  = 4;
  localparam logic [15:0] Data = 16'h1000;
  localparam logic [15:0] Stat = 16'h2000;

  logic        clk, resetq, io_rd, io_wr, uart_rx, uart_tx;
  logic [15:0] mem_addr, dout, io_din;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: received bytes, sticky overrun, transmitter busy.
  logic [7:0] q[$];
  logic       m_ov   = 1'b0;
  logic       m_busy = 1'b0;

  j1_uart_io #(
    .CLKS_PER_BIT(Cpb),
    .WIDTH       (16)
  ) dut (
    .clk     (clk),
    .resetq  (resetq),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .mem_addr(mem_addr),
    .dout    (dout),
    .io_din  (io_din),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_din;
    logic        exp_tx;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h want 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a read returns now, plus its side effects on the model.
  task automatic model_read(input logic [15:0] addr, output logic [15:0] exp);
    exp = '0;
    if (addr == Data) begin
      if (q.size() > 0) exp = {8'h00, q.pop_front()};
    end else if (addr == Stat) begin
      exp  = {13'd0, m_ov, q.size() != 0, m_busy};
      m_ov = 1'b0;
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() == 4) m_ov = 1'b1;
    else               q.push_back(b);
  endtask

  task automatic read_check(input string name, input logic [15:0] addr);
    logic [15:0] exp;
    model_read(addr, exp);
    io_rd    = 1'b1;
    mem_addr = addr;
    #3;
    chk(name, io_din, exp);
    tick();
    io_rd    = 1'b0;
    mem_addr = '0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] val);
    io_wr    = 1'b1;
    mem_addr = addr;
    dout     = val;
    tick();
    io_wr    = 1'b0;
    mem_addr = '0;
  endtask

  // Serial frame into uart_rx; a read of rd_addr is issued in the cycle the
  // byte lands in the FIFO (address 0 makes it a no-op read).
  task automatic rx_send(input logic [7:0] b, input logic stop, input logic [15:0] rd_addr);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (Cpb) tick();
    end
    uart_rx = 1'b1;
    read_check("rx_push_cycle_read", rd_addr);
    if (stop) model_push(b);
    repeat (Cpb) tick();
  endtask

  task automatic drain();
    read_check("drain_stat", Stat);
    while (q.size() > 0) read_check("drain_data", Data);
    read_check("drain_empty", Data);
  endtask

  // Transmit one byte and follow the line and STAT every cycle. second_at
  // issues an extra write during the frame; reset_at pulses reset instead.
  task automatic tx_frame(input logic [7:0] b, input int second_at, input int reset_at);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    do_write(Data, {8'hC3, b});
    m_busy = 1'b1;
    for (int k = 0; k < 10 * Cpb; k++) begin
      if (k == reset_at) begin
        resetq = 1'b0;
        tick();
        resetq = 1'b1;
        q.delete();
        m_ov   = 1'b0;
        m_busy = 1'b0;
        chk("tx_after_reset", {15'd0, uart_tx}, 16'd1);
        read_check("stat_after_reset", Stat);
        return;
      end
      chk("tx_bit", {15'd0, uart_tx}, {15'd0, bits[k / Cpb]});
      if (k == second_at) do_write(Data, {8'h00, ~b});
      else                read_check("tx_stat", Stat);
    end
    m_busy = 1'b0;
    chk("tx_idle", {15'd0, uart_tx}, 16'd1);
    read_check("tx_stat_done", Stat);
  endtask

  initial begin
    logic [15:0] exp;
    resetq   = 1'b0;
    io_rd    = 1'b0;
    io_wr    = 1'b0;
    mem_addr = '0;
    dout     = '0;
    uart_rx  = 1'b1;

    // Register-access vectors from the reset state.
    vecs[0]  = '{1'b1, 1'b0, Stat,     16'h0000, 16'h0000, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, Data,     16'h0000, 16'h0000, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, Stat,     16'h00FF, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 16'h1001, 16'h0055, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 16'h0FFF, 16'h0055, 16'h0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, Data,     16'h1200, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, Stat,     16'h0000, 16'h0001, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, Data,     16'h00FF, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, Data,     16'h0000, 16'h0000, 1'b0};

    repeat (3) tick();
    chk("rst_tx", {15'd0, uart_tx}, 16'd1);
    mem_addr = Stat;
    #1 chk("rst_stat", io_din, 16'h0000);
    mem_addr = Data;
    #1 chk("rst_data", io_din, 16'h0000);
    mem_addr = '0;
    resetq   = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      io_rd    = vecs[i].rd;
      io_wr    = vecs[i].wr;
      mem_addr = vecs[i].addr;
      dout     = vecs[i].data;
      #3;
      chk($sformatf("vec%0d_din", i), io_din, vecs[i].exp_din);
      tick();
      io_rd    = 1'b0;
      io_wr    = 1'b0;
      mem_addr = '0;
      chk($sformatf("vec%0d_tx", i), {15'd0, uart_tx}, {15'd0, vecs[i].exp_tx});
    end
    repeat (10 * Cpb) tick();
    chk("vec_tx_idle", {15'd0, uart_tx}, 16'd1);
    read_check("vec_stat_idle", Stat);

    // Single transmit of 0xA5.
    tx_frame(8'hA5, -1, -1);

    // One received byte.
    rx_send(8'h3C, 1'b1, 16'h0000);
    read_check("rx1_stat", Stat);
    read_check("rx1_data", Data);
    read_check("rx1_stat_after", Stat);

    // Five bytes with no reads: fifth overruns.
    for (int i = 1; i <= 5; i++) rx_send(8'(i), 1'b1, 16'h0000);
    read_check("ovr_stat", Stat);
    read_check("ovr_stat_cleared", Stat);
    for (int i = 0; i < 5; i++) read_check("ovr_data", Data);

    // Glitch on the line and a frame with a bad stop bit.
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (4 * Cpb) tick();
    read_check("glitch_stat", Stat);
    rx_send(8'h81, 1'b0, 16'h0000);
    read_check("framing_stat", Stat);

    // Full FIFO: pop in the push cycle, then STAT clear in the push cycle.
    for (int i = 0; i < 4; i++) rx_send(8'h10 + 8'(i), 1'b1, 16'h0000);
    rx_send(8'h99, 1'b1, Data);
    drain();
    for (int i = 0; i < 4; i++) rx_send(8'h20 + 8'(i), 1'b1, 16'h0000);
    rx_send(8'h77, 1'b1, Stat);
    drain();

    // Read and write strobes together on DATA.
    rx_send(8'h5A, 1'b1, 16'h0000);
    model_read(Data, exp);
    io_rd    = 1'b1;
    io_wr    = 1'b1;
    mem_addr = Data;
    dout     = 16'h000F;
    #3 chk("rdwr_din", io_din, exp);
    tick();
    io_rd    = 1'b0;
    io_wr    = 1'b0;
    mem_addr = '0;
    m_busy   = 1'b1;
    chk("rdwr_tx_start", {15'd0, uart_tx}, 16'd0);
    read_check("rdwr_stat", Stat);
    repeat (10 * Cpb) tick();
    m_busy = 1'b0;
    read_check("rdwr_stat_done", Stat);

    // Ignored second write, then reset in mid-frame.
    tx_frame(8'($urandom), 9, -1);
    tx_frame(8'($urandom), -1, 17);

    // Randomised receive bursts with reads dropped into push cycles.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) begin
        logic [15:0] a;
        int sel;
        sel = $urandom_range(0, 5);
        a   = (sel == 0) ? Data : (sel == 1) ? Stat : 16'h0000;
        rx_send(8'($urandom), $urandom_range(0, 7) != 0, a);
      end
      drain();
    end
    for (int t = 0; t < 2; t++) tx_frame(8'($urandom), -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
